// File: rtl/fixed_unsigned_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fixed_unsigned_accumulator
// Brief    : Sums IN_DEPTH consecutive unsigned fixed-point beats into one wide
//            registered result with valid/ready on both sides. The optional
//            saturating mode with overflow flag is enabled by defining
//            FIXED_UNSIGNED_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_unsigned_accumulator #(
    parameter int IN_WIDTH      = 8,
    parameter int IN_FRAC_WIDTH = 4,
    parameter int IN_DEPTH      = 4,
    parameter int OUT_WIDTH     = IN_WIDTH + $clog2(IN_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
    ,
    output logic                 overflow
`endif
);

    localparam int c_CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    if (IN_DEPTH < 1) begin : g_chk_depth
        $error("fixed_unsigned_accumulator: IN_DEPTH must be >= 1");
    end
    if (OUT_WIDTH < IN_WIDTH) begin : g_chk_out_width
        $error("fixed_unsigned_accumulator: OUT_WIDTH must be >= IN_WIDTH");
    end
    if ((IN_FRAC_WIDTH < 0) || (IN_FRAC_WIDTH > IN_WIDTH)) begin : g_chk_frac
        $error("fixed_unsigned_accumulator: IN_FRAC_WIDTH out of range");
    end

    logic [c_CNT_W-1:0]   r_cnt;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_out;
    logic                 r_out_valid;

    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_last;
    logic [OUT_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH-1:0] w_sum;

    // Ready only depends on the output slot, so a finished sum is never overwritten.
    assign w_in_ready = ~r_out_valid | data_out_ready;
    assign w_in_fire  = data_in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & data_out_ready;
    assign w_last     = (r_cnt == c_LAST);
    assign w_ext      = OUT_WIDTH'(data_in);

`ifdef FIXED_UNSIGNED_ACC_SAT_EN
    logic [OUT_WIDTH:0] w_sum_wide;
    logic               w_carry;
    logic               r_ovf_acc;
    logic               r_overflow;

    assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_carry    = w_sum_wide[OUT_WIDTH];
    // Once a block has clamped it stays at all-ones until the block closes.
    assign w_sum      = (w_carry | r_ovf_acc) ? {OUT_WIDTH{1'b1}} : w_sum_wide[OUT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_acc  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_in_fire) begin
            if (w_last) begin
                r_overflow <= r_ovf_acc | w_carry;
                r_ovf_acc  <= 1'b0;
            end else begin
                r_ovf_acc  <= r_ovf_acc | w_carry;
            end
        end
    end

    assign overflow = r_overflow;
`else
    assign w_sum = r_acc + w_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_last) begin
                    r_out <= w_sum;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_ONE;
                end
            end
            // A new sum loading takes priority over the drain of the old one.
            if (w_in_fire && w_last) begin
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign data_in_ready  = w_in_ready;
    assign data_out       = r_out;
    assign data_out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fixed_unsigned_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_unsigned_accumulator
// Brief    : Scoreboard bench driving three accumulator configurations (depth 4
//            / width 10, depth 1, depth 4 / width 9) from one shared stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_unsigned_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_out_ready;

    logic       m_ready, m_valid;
    logic [9:0] m_out;
    logic       s_ready, s_valid;
    logic [7:0] s_out;
    logic       w_ready, w_valid;
    logic [8:0] w_out;
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
    logic       m_ovf, s_ovf, w_ovf;
`endif

    always #5 clk = ~clk;

    fixed_unsigned_accumulator #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .IN_DEPTH(4), .OUT_WIDTH(10)) u_main (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(m_ready), .data_out(m_out), .data_out_valid(m_valid),
        .data_out_ready(data_out_ready)
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        , .overflow(m_ovf)
`endif
    );

    fixed_unsigned_accumulator #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .IN_DEPTH(1), .OUT_WIDTH(8)) u_single (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(s_ready), .data_out(s_out), .data_out_valid(s_valid),
        .data_out_ready(data_out_ready)
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        , .overflow(s_ovf)
`endif
    );

    fixed_unsigned_accumulator #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .IN_DEPTH(4), .OUT_WIDTH(9)) u_wrap (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(w_ready), .data_out(w_out), .data_out_valid(w_valid),
        .data_out_ready(data_out_ready)
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        , .overflow(w_ovf)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    int m_q[$];
    int s_q[$];
    int w_q[$];
    int ov_q[$];

    int m_acc = 0;
    int w_acc = 0;
    int w_sticky = 0;
    int blk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour of all three instances for one accepted beat.
    task automatic model_accept(input int v);
        int t;
        s_q.push_back(v);
        m_acc = (m_acc + v) % 1024;
        t = w_acc + v;
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        if (t > 511) begin
            t = 511;
            w_sticky = 1;
        end
`else
        t = t % 512;
`endif
        w_acc = t;
        blk_cnt++;
        if (blk_cnt == 4) begin
            m_q.push_back(m_acc);
            w_q.push_back(w_acc);
            ov_q.push_back(w_sticky);
            m_acc = 0;
            w_acc = 0;
            w_sticky = 0;
            blk_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        w_acc = 0;
        w_sticky = 0;
        blk_cnt = 0;
        m_q.delete();
        s_q.delete();
        w_q.delete();
        ov_q.delete();
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns with the beat taken.
    task automatic beat(input logic [7:0] v, output int waits);
        waits = 0;
        data_in       = v;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (m_ready !== 1'b1) begin
            waits++;
            if (waits > 100) begin
                $display("FAIL beat_accept_timeout: observed no acceptance required acceptance of 0x%0h", v);
                $fatal(1, "beat acceptance timeout");
            end
            @(negedge clk);
        end
        model_accept(int'(v));
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && data_out_ready) begin
            n_total++;
            assert (m_q.size() != 0) n_pass++;
            else $error("FAIL main_stray_output: observed 0x%0h required no output", m_out);
            if (m_q.size() != 0) check("main_sum", 32'(m_out), 32'(m_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && s_valid && data_out_ready) begin
            n_total++;
            assert (s_q.size() != 0) n_pass++;
            else $error("FAIL single_stray_output: observed 0x%0h required no output", s_out);
            if (s_q.size() != 0) check("single_sum", 32'(s_out), 32'(s_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && w_valid && data_out_ready) begin
            n_total++;
            assert (w_q.size() != 0) n_pass++;
            else $error("FAIL w9_stray_output: observed 0x%0h required no output", w_out);
            if (w_q.size() != 0) begin
                check("w9_sum", 32'(w_out), 32'(w_q.pop_front()));
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
                check("w9_overflow", 32'(w_ovf), 32'(ov_q.pop_front()));
`else
                void'(ov_q.pop_front());
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int wt;
        logic [31:0] exp_w;

        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_out",   32'(m_out),   32'h0);
        check("reset_m_valid", 32'(m_valid), 32'h0);
        check("reset_s_valid", 32'(s_valid), 32'h0);
        check("reset_w_valid", 32'(w_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single block, one-cycle latency, single-cycle valid.
        beat(8'h10, wt);
        beat(8'h20, wt);
        beat(8'h30, wt);
        beat(8'h40, wt);
        @(negedge clk);
        check("t1_latency_valid", 32'(m_valid), 32'h1);
        check("t1_latency_data",  32'(m_out),   32'h0A0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(m_valid), 32'h0);
        @(posedge clk);
        #1;

        // Back-to-back blocks with no bubble.
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i), wt);
            check("b2b_no_wait", 32'(wt), 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;

        // Completed sum held under backpressure.
        for (int i = 1; i <= 4; i++) beat(8'(i), wt);
        data_out_ready = 1'b0;
        data_in        = 8'd5;
        data_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data",     32'(m_out),   32'd10);
            check("stall_valid",    32'(m_valid), 32'h1);
            check("stall_in_ready", 32'(m_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        data_out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) beat(8'(i), wt);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a block discards partial and pending state.
        beat(8'hFF, wt);
        beat(8'hFF, wt);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_m_valid_dropped", 32'(m_valid), 32'h0);
        check("rst_s_valid_dropped", 32'(s_valid), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) beat(8'h01, wt);
        @(negedge clk);
        check("rst_first_sum", 32'(m_out), 32'd4);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Depth-1 instance behaves as a register stage.
        beat(8'h07, wt);
        @(negedge clk);
        check("single_latency_valid", 32'(s_valid), 32'h1);
        check("single_latency_7",     32'(s_out),   32'h007);
        @(posedge clk);
        #1;
        beat(8'h09, wt);
        @(negedge clk);
        check("single_latency_9", 32'(s_out), 32'h009);
        @(posedge clk);
        #1;
        beat(8'h00, wt);
        beat(8'h00, wt);

        // 9-bit accumulator: saturation or wrap, then a clean block.
        for (int i = 0; i < 4; i++) beat(8'hFF, wt);
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        exp_w = 32'h1FF;
`else
        exp_w = 32'h1FC;
`endif
        @(negedge clk);
        check("w9_edge_sum", 32'(w_out), exp_w);
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        check("w9_edge_overflow", 32'(w_ovf), 32'h1);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) beat(8'h01, wt);
        @(negedge clk);
        check("w9_after_sum", 32'(w_out), 32'd4);
`ifdef FIXED_UNSIGNED_ACC_SAT_EN
        check("w9_after_overflow", 32'(w_ovf), 32'h0);
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("m_q_drained", 32'(m_q.size()), 32'h0);
        check("s_q_drained", 32'(s_q.size()), 32'h0);
        check("w_q_drained", 32'(w_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
